path_list: RTL

//   Parametrised move-history buffer for the maze solver. Records moves as the

---
 rtl/path_list.sv | 127 ++++++++++++
 1 files changed

// File: rtl/path_list.sv
// rtl/path_list.sv - move-history buffer with push/pop backtrack and LIFO/FIFO stream replay
module path_list #(
  parameter int MAX_LENGTH = 256,
  parameter int WIDTH      = 2,
  parameter int PTR_W      = $clog2(MAX_LENGTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  input  logic             rd_start,
  input  logic             rd_mode,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             out_last,
  output logic             rd_busy,
  output logic             rd_done,
  output logic [PTR_W:0]   length,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int LEN_W = PTR_W + 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] READ = 1'b1;

  logic [WIDTH-1:0] mem [MAX_LENGTH];
  logic [0:0]       state;
  logic             mode;
  logic [PTR_W-1:0] rd_idx;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] top_ptr;
  logic [PTR_W-1:0] nxt_idx;
  logic [PTR_W-1:0] last_idx;
  logic [PTR_W-1:0] wr_addr;
  logic             do_write;
  logic             xfer;

  assign full     = (length == LEN_W'(MAX_LENGTH));
  assign empty    = (length == '0);
  assign rd_busy  = (state == READ);
  assign xfer     = out_valid && out_ready;
  assign wr_ptr   = PTR_W'(length);
  assign top_ptr  = PTR_W'(length - LEN_W'(1));
  assign nxt_idx  = mode ? (rd_idx + PTR_W'(1)) : (rd_idx - PTR_W'(1));
  assign last_idx = mode ? top_ptr : '0;

  // push&&pop on a non-empty list rewrites the newest entry in place
  always_comb begin
    do_write = 1'b0;
    wr_addr  = wr_ptr;
    if (state == IDLE && !init && push) begin
      if (pop && !empty) begin
        do_write = 1'b1;
        wr_addr  = top_ptr;
      end else if (!full) begin
        do_write = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_addr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mode      <= 1'b0;
      rd_idx    <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      out_last  <= 1'b0;
      rd_done   <= 1'b0;
      length    <= '0;
      overflow  <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      if (init) begin
        state     <= IDLE;
        mode      <= 1'b0;
        rd_idx    <= '0;
        out_valid <= 1'b0;
        data_out  <= '0;
        out_last  <= 1'b0;
        length    <= '0;
        overflow  <= 1'b0;
      end else if (state == IDLE) begin
        if (push && pop) begin
          if (empty) length <= length + LEN_W'(1);
        end else if (push) begin
          if (!full) length <= length + LEN_W'(1);
          else       overflow <= 1'b1;
        end else if (pop) begin
          if (!empty) length <= length - LEN_W'(1);
        end else if (rd_start) begin
          if (empty) begin
            rd_done <= 1'b1;
          end else begin
            state     <= READ;
            mode      <= rd_mode;
            out_valid <= 1'b1;
            rd_idx    <= rd_mode ? '0 : top_ptr;
            data_out  <= mem[rd_mode ? '0 : top_ptr];
            out_last  <= (length == LEN_W'(1));
          end
        end
      end else if (xfer) begin
        if (out_last) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          rd_done   <= 1'b1;
        end else begin
          rd_idx   <= nxt_idx;
          data_out <= mem[nxt_idx];
          out_last <= (nxt_idx == last_idx);
        end
      end
    end
  end

endmodule
